// File: rtl/c_mod_packetizer.sv
// Sample-to-byte packetizer feeding the c_mod_input Avalon-ST sink.
// Packet: HEADER, SEQ, {hi, lo} per sample, CSUM. A packet starts only once its whole payload is buffered.
module c_mod_packetizer #(
    parameter int unsigned SAMPLES_PER_PKT = 4,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter logic [7:0]  HEADER          = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [15:0]                   sample_data,
    input  logic                          clear_status,
    output logic                          out_valid,
    output logic                          out_startofpacket,
    output logic [7:0]                    out_data,
    output logic                          out_endofpacket,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(SAMPLES_PER_PKT + 1);

    typedef enum logic [2:0] {StIdle, StHdr, StSeq, StPh, StPl, StCsum} state_e;

    state_e         state_q, state_d;
    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q, rd_ptr_inc, wr_ptr_inc;
    logic [LW-1:0]  level_q, level_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     seq_q, seq_d, csum_q, csum_d;
    logic           valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [7:0]     data_q, data_d, byte_sel;
    logic           overflow_q, overflow_d;
    logic [15:0]    drops_q, drops_d;
    logic [15:0]    head;
    logic           full, push, pop, drop, start;

    assign rd_ptr_inc = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    assign wr_ptr_inc = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign pop   = (state_q == StPl);
    assign push  = sample_valid && enable && (!full || pop);
    assign drop  = sample_valid && enable && full && !pop;
    assign start = enable && (level_q >= LW'(SAMPLES_PER_PKT));

    // A PH byte chosen while the current word pops must come from the following word.
    assign head = pop ? mem_q[rd_ptr_inc] : mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seq_d    = seq_q;
        csum_d   = csum_q;
        valid_d  = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        data_d   = 8'h00;
        byte_sel = 8'h00;

        unique case (state_q)
            StIdle: if (start) state_d = StHdr;
            StHdr: begin
                state_d = StSeq;
                cnt_d   = '0;
            end
            StSeq: state_d = StPh;
            StPh:  state_d = StPl;
            StPl: begin
                if (cnt_q == CW'(SAMPLES_PER_PKT - 1)) begin
                    state_d = StCsum;
                end else begin
                    state_d = StPh;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            StCsum: begin
                seq_d   = seq_q + 8'd1;
                state_d = start ? StHdr : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered alongside the state, so decode the state being entered.
        case (state_d)
            StHdr: begin
                valid_d = 1'b1;
                sop_d   = 1'b1;
                data_d  = HEADER;
            end
            StSeq: begin
                valid_d = 1'b1;
                data_d  = seq_q;
                csum_d  = seq_q;
            end
            StPh, StPl: begin
                byte_sel = (state_d == StPh) ? head[15:8] : head[7:0];
                valid_d  = 1'b1;
                data_d   = byte_sel;
                csum_d   = csum_q + byte_sel;
            end
            StCsum: begin
                valid_d = 1'b1;
                eop_d   = 1'b1;
                data_d  = csum_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (clear_status) begin
            overflow_d = 1'b0;
            drops_d    = 16'h0000;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= 8'h00;
            overflow_q <= 1'b0;
            drops_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            if (pop)  rd_ptr_q <= rd_ptr_inc;
            if (push) wr_ptr_q <= wr_ptr_inc;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;
    assign out_data          = data_q;
    assign overflow          = overflow_q;
    assign drop_count        = drops_q;
    assign fifo_level        = level_q;

endmodule
